// File: rtl/ps2_defs.sv
// Shared PS/2 decoder definitions: prefix bytes, pause tail length and
// decoder state encodings used by the key tracker.
package ps2_defs;

   localparam logic [7:0] PFX_EXT   = 8'hE0;
   localparam logic [7:0] PFX_BRK   = 8'hF0;
   localparam logic [7:0] PFX_PAUSE = 8'hE1;

   // Bytes that follow E1 in the Pause/Break make sequence.
   localparam logic [2:0] PAUSE_TAIL_BYTES = 3'd7;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_EXT     = 3'd1,
      ST_BRK     = 3'd2,
      ST_EXT_BRK = 3'd3,
      ST_PAUSE   = 3'd4
   } dec_state_t;

endpackage

// File: rtl/ps2_key_slot.sv
// One tracked key: holds the key-down level and produces the press/release
// pulses when a completed code matches this slot's 9-bit {extended, code}.
module ps2_key_slot #(
   parameter logic [8:0] KEY = 9'h000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       clear_all,
   input  logic       complete,
   input  logic [8:0] code,
   input  logic       brk,
   output logic       held,
   output logic       pressed,
   output logic       released
);

   // Track held level; pulse only on real transitions so typematic repeats
   // and stray breaks stay silent.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         held     <= 1'b0;
         pressed  <= 1'b0;
         released <= 1'b0;
      end else if (clear_all) begin
         held     <= 1'b0;
         pressed  <= 1'b0;
         released <= 1'b0;
      end else if (complete && (code == KEY)) begin
         if (brk) begin
            released <= held;
            pressed  <= 1'b0;
            held     <= 1'b0;
         end else begin
            pressed  <= ~held;
            released <= 1'b0;
            held     <= 1'b1;
         end
      end else begin
         pressed  <= 1'b0;
         released <= 1'b0;
      end
   end

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 scan-code set 2 decoder and key-state tracker. Bytes arrive as
// single-cycle strobes; completed make/break codes update the per-slot
// held/pulse outputs and the last-code registers one cycle later.
module ps2_key_tracker
   import ps2_defs::*;
#(
   parameter int NUM_KEYS = 6,
   parameter logic [NUM_KEYS*9-1:0] KEY_CODES =
      {9'h16B, 9'h029, 9'h02B, 9'h023, 9'h01B, 9'h01C},
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic                CLOCK_50,
   input  logic                reset,
   input  logic [7:0]          received_data,
   input  logic                received_data_en,
   input  logic                clear_all,
   output logic [NUM_KEYS-1:0] keys_held,
   output logic [NUM_KEYS-1:0] key_pressed,
   output logic [NUM_KEYS-1:0] key_released,
   output logic [8:0]          last_code,
   output logic                last_break,
   output logic                code_valid,
   output logic                seq_error
);

   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   dec_state_t       state_r;
   dec_state_t       next_s;
   logic [TMO_W-1:0] tmo_cnt_r;
   logic [2:0]       pause_cnt_r;
   logic             complete_s;
   logic [8:0]       code_s;
   logic             brk_s;
   logic             perr_s;
   logic             strobe_s;

   // A strobe coinciding with clear_all is dropped.
   assign strobe_s = received_data_en & ~clear_all;

   // Classify the incoming byte against the current decoder state.
   always_comb begin
      next_s     = state_r;
      complete_s = 1'b0;
      code_s     = 9'h000;
      brk_s      = 1'b0;
      perr_s     = 1'b0;
      if (strobe_s) begin
         case (state_r)
            ST_IDLE: begin
               if (received_data == PFX_EXT) begin
                  next_s = ST_EXT;
               end else if (received_data == PFX_BRK) begin
                  next_s = ST_BRK;
               end else if (received_data == PFX_PAUSE) begin
                  next_s = ST_PAUSE;
               end else begin
                  complete_s = 1'b1;
                  code_s     = {1'b0, received_data};
                  next_s     = ST_IDLE;
               end
            end
            ST_EXT: begin
               if (received_data == PFX_BRK) begin
                  next_s = ST_EXT_BRK;
               end else if (received_data == PFX_EXT) begin
                  perr_s = 1'b1;
                  next_s = ST_EXT;
               end else if (received_data == PFX_PAUSE) begin
                  perr_s = 1'b1;
                  next_s = ST_PAUSE;
               end else begin
                  complete_s = 1'b1;
                  code_s     = {1'b1, received_data};
                  next_s     = ST_IDLE;
               end
            end
            ST_BRK, ST_EXT_BRK: begin
               // A prefix here is malformed; restart with it as a new first byte.
               if (received_data == PFX_EXT) begin
                  perr_s = 1'b1;
                  next_s = ST_EXT;
               end else if (received_data == PFX_BRK) begin
                  perr_s = 1'b1;
                  next_s = ST_BRK;
               end else if (received_data == PFX_PAUSE) begin
                  perr_s = 1'b1;
                  next_s = ST_PAUSE;
               end else begin
                  complete_s = 1'b1;
                  brk_s      = 1'b1;
                  code_s     = {(state_r == ST_EXT_BRK), received_data};
                  next_s     = ST_IDLE;
               end
            end
            ST_PAUSE: begin
               if (pause_cnt_r == (PAUSE_TAIL_BYTES - 3'd1)) begin
                  next_s = ST_IDLE;
               end else begin
                  next_s = ST_PAUSE;
               end
            end
            default: begin
               next_s = ST_IDLE;
            end
         endcase
      end else begin
         next_s = state_r;
      end
   end

   // Decoder state, pause/timeout counters and the registered code outputs.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state_r     <= ST_IDLE;
         tmo_cnt_r   <= {TMO_W{1'b0}};
         pause_cnt_r <= 3'd0;
         last_code   <= 9'h000;
         last_break  <= 1'b0;
         code_valid  <= 1'b0;
         seq_error   <= 1'b0;
      end else if (clear_all) begin
         state_r     <= ST_IDLE;
         tmo_cnt_r   <= {TMO_W{1'b0}};
         pause_cnt_r <= 3'd0;
         code_valid  <= 1'b0;
         seq_error   <= 1'b0;
      end else begin
         code_valid <= complete_s;
         seq_error  <= perr_s;
         if (complete_s) begin
            last_code  <= code_s;
            last_break <= brk_s;
         end else begin
            last_code  <= last_code;
            last_break <= last_break;
         end
         if (received_data_en) begin
            state_r   <= next_s;
            tmo_cnt_r <= {TMO_W{1'b0}};
            if ((state_r == ST_PAUSE) && (next_s == ST_PAUSE)) begin
               pause_cnt_r <= pause_cnt_r + 3'd1;
            end else begin
               pause_cnt_r <= 3'd0;
            end
         end else if (state_r != ST_IDLE) begin
            if (tmo_cnt_r == TMO_LAST) begin
               // Abandon a prefix that was never finished.
               state_r     <= ST_IDLE;
               tmo_cnt_r   <= {TMO_W{1'b0}};
               pause_cnt_r <= 3'd0;
               seq_error   <= 1'b1;
            end else begin
               tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
            end
         end else begin
            tmo_cnt_r <= {TMO_W{1'b0}};
         end
      end
   end

   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_slot
      ps2_key_slot #(
         .KEY(KEY_CODES[9*i +: 9])
      ) u_slot (
         .clk      (CLOCK_50),
         .reset    (reset),
         .clear_all(clear_all),
         .complete (complete_s),
         .code     (code_s),
         .brk      (brk_s),
         .held     (keys_held[i]),
         .pressed  (key_pressed[i]),
         .released (key_released[i])
      );
   end

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Self-checking bench for ps2_key_tracker: directed vector table, hand-written
// timeout and reset sequences, then random bytes against a queue-based model.
module tb_ps2_key_tracker;

   localparam int NK  = 6;
   localparam int TMO = 40;
   localparam logic [NK*9-1:0] KEYS =
      {9'h16B, 9'h029, 9'h02B, 9'h023, 9'h01B, 9'h01C};

   logic          CLOCK_50 = 1'b0;
   logic          reset = 1'b1;
   logic [7:0]    received_data = 8'h00;
   logic          received_data_en = 1'b0;
   logic          clear_all = 1'b0;
   logic [NK-1:0] keys_held, key_pressed, key_released;
   logic [8:0]    last_code;
   logic          last_break, code_valid, seq_error;

   int errors = 0;
   int checks = 0;

   logic [NK*9-1:0] key_tab;
   assign key_tab = KEYS;

   // Reference model state.
   logic [NK-1:0] m_held, m_pr, m_rel;
   logic [8:0]    m_code;
   logic          m_brk, m_cv, m_err;
   logic [7:0]    m_pend[$];
   int            m_pause;
   int            m_idle;

   typedef struct {
      logic       en;
      logic [7:0] data;
      logic       clr;
      logic [5:0] held;
      logic [5:0] pr;
      logic [5:0] rel;
      logic       cv;
      logic [8:0] code;
      logic       brk;
      logic       err;
   } vec_t;
   vec_t tbl[$];

   ps2_key_tracker #(
      .NUM_KEYS(NK),
      .KEY_CODES(KEYS),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .CLOCK_50(CLOCK_50),
      .reset(reset),
      .received_data(received_data),
      .received_data_en(received_data_en),
      .clear_all(clear_all),
      .keys_held(keys_held),
      .key_pressed(key_pressed),
      .key_released(key_released),
      .last_code(last_code),
      .last_break(last_break),
      .code_valid(code_valid),
      .seq_error(seq_error)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_held = '0; m_pr = '0; m_rel = '0;
      m_code = 9'h000; m_brk = 1'b0; m_cv = 1'b0; m_err = 1'b0;
      m_pend.delete();
      m_pause = 0;
      m_idle = 0;
   endtask

   task automatic model_complete(input logic [8:0] code, input logic brk);
      m_cv = 1'b1;
      m_code = code;
      m_brk = brk;
      for (int i = 0; i < NK; i++) begin
         if (key_tab[9*i +: 9] == code) begin
            if (!brk && !m_held[i]) begin
               m_pr[i] = 1'b1;
               m_held[i] = 1'b1;
            end else if (brk && m_held[i]) begin
               m_rel[i] = 1'b1;
               m_held[i] = 1'b0;
            end
         end
      end
   endtask

   // Pending prefixes are kept as a list; a non-prefix byte finishes the code.
   task automatic model_byte(input logic [7:0] b);
      logic has_e0, has_f0;
      has_e0 = 1'b0;
      has_f0 = 1'b0;
      if (m_pause > 0) begin
         m_pause--;
      end else begin
         foreach (m_pend[k]) begin
            if (m_pend[k] == 8'hE0) has_e0 = 1'b1;
            if (m_pend[k] == 8'hF0) has_f0 = 1'b1;
         end
         if (b == 8'hE1) begin
            if (m_pend.size() > 0) m_err = 1'b1;
            m_pend.delete();
            m_pause = 7;
         end else if (b == 8'hE0) begin
            if (m_pend.size() > 0) m_err = 1'b1;
            m_pend.delete();
            m_pend.push_back(b);
         end else if (b == 8'hF0) begin
            if (has_f0) begin
               m_err = 1'b1;
               m_pend.delete();
            end
            m_pend.push_back(b);
         end else begin
            model_complete({has_e0, b}, has_f0);
            m_pend.delete();
         end
      end
   endtask

   task automatic model_step(input logic en, input logic [7:0] d, input logic clr);
      m_pr = '0; m_rel = '0; m_cv = 1'b0; m_err = 1'b0;
      if (clr) begin
         m_held = '0;
         m_pend.delete();
         m_pause = 0;
         m_idle = 0;
      end else if (en) begin
         m_idle = 0;
         model_byte(d);
      end else if (m_pend.size() > 0 || m_pause > 0) begin
         m_idle++;
         if (m_idle == TMO) begin
            m_err = 1'b1;
            m_pend.delete();
            m_pause = 0;
            m_idle = 0;
         end
      end else begin
         m_idle = 0;
      end
   endtask

   // Drive one cycle of inputs from a negedge, step the model, return at next negedge.
   task automatic drive_cycle(input logic en, input logic [7:0] d, input logic clr);
      received_data_en = en;
      received_data = d;
      clear_all = clr;
      @(posedge CLOCK_50);
      model_step(en, d, clr);
      @(negedge CLOCK_50);
      received_data_en = 1'b0;
      clear_all = 1'b0;
   endtask

   task automatic check_model(input string tag);
      check({tag, " held"},     32'(keys_held),    32'(m_held));
      check({tag, " pressed"},  32'(key_pressed),  32'(m_pr));
      check({tag, " released"}, 32'(key_released), 32'(m_rel));
      check({tag, " code"},     32'(last_code),    32'(m_code));
      check({tag, " brk"},      32'(last_break),   32'(m_brk));
      check({tag, " cv"},       32'(code_valid),   32'(m_cv));
      check({tag, " err"},      32'(seq_error),    32'(m_err));
   endtask

   task automatic add(input logic en, input logic [7:0] d, input logic clr,
                      input logic [5:0] h, input logic [5:0] pr, input logic [5:0] rel,
                      input logic cv, input logic [8:0] c, input logic b, input logic e);
      vec_t v;
      v.en = en; v.data = d; v.clr = clr; v.held = h; v.pr = pr; v.rel = rel;
      v.cv = cv; v.code = c; v.brk = b; v.err = e;
      tbl.push_back(v);
   endtask

   initial begin
      logic [7:0] pause_tail[7];
      logic [7:0] b;
      logic       en;
      logic       clr;
      pause_tail = '{8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

      // Directed vectors (inputs, expected outputs one cycle later).
      add(1'b1, 8'h1C, 1'b0, 6'h01, 6'h01, 6'h00, 1'b1, 9'h01C, 1'b0, 1'b0);
      add(1'b0, 8'h00, 1'b0, 6'h01, 6'h00, 6'h00, 1'b0, 9'h01C, 1'b0, 1'b0);
      add(1'b1, 8'h1C, 1'b0, 6'h01, 6'h00, 6'h00, 1'b1, 9'h01C, 1'b0, 1'b0);
      add(1'b1, 8'h1C, 1'b0, 6'h01, 6'h00, 6'h00, 1'b1, 9'h01C, 1'b0, 1'b0);
      add(1'b1, 8'hF0, 1'b0, 6'h01, 6'h00, 6'h00, 1'b0, 9'h01C, 1'b0, 1'b0);
      add(1'b1, 8'h1C, 1'b0, 6'h00, 6'h00, 6'h01, 1'b1, 9'h01C, 1'b1, 1'b0);
      add(1'b0, 8'h00, 1'b0, 6'h00, 6'h00, 6'h00, 1'b0, 9'h01C, 1'b1, 1'b0);
      add(1'b1, 8'hE0, 1'b0, 6'h00, 6'h00, 6'h00, 1'b0, 9'h01C, 1'b1, 1'b0);
      add(1'b1, 8'h6B, 1'b0, 6'h20, 6'h20, 6'h00, 1'b1, 9'h16B, 1'b0, 1'b0);
      add(1'b1, 8'h6B, 1'b0, 6'h20, 6'h00, 6'h00, 1'b1, 9'h06B, 1'b0, 1'b0);
      add(1'b1, 8'hE0, 1'b0, 6'h20, 6'h00, 6'h00, 1'b0, 9'h06B, 1'b0, 1'b0);
      add(1'b1, 8'hF0, 1'b0, 6'h20, 6'h00, 6'h00, 1'b0, 9'h06B, 1'b0, 1'b0);
      add(1'b1, 8'h6B, 1'b0, 6'h00, 6'h00, 6'h20, 1'b1, 9'h16B, 1'b1, 1'b0);
      add(1'b1, 8'hE1, 1'b0, 6'h00, 6'h00, 6'h00, 1'b0, 9'h16B, 1'b1, 1'b0);
      for (int i = 0; i < 7; i++) begin
         add(1'b1, pause_tail[i], 1'b0, 6'h00, 6'h00, 6'h00, 1'b0, 9'h16B, 1'b1, 1'b0);
      end
      add(1'b1, 8'h1B, 1'b0, 6'h02, 6'h02, 6'h00, 1'b1, 9'h01B, 1'b0, 1'b0);
      add(1'b1, 8'hF0, 1'b0, 6'h02, 6'h00, 6'h00, 1'b0, 9'h01B, 1'b0, 1'b0);
      add(1'b1, 8'hE0, 1'b0, 6'h02, 6'h00, 6'h00, 1'b0, 9'h01B, 1'b0, 1'b1);
      add(1'b1, 8'h6B, 1'b0, 6'h22, 6'h20, 6'h00, 1'b1, 9'h16B, 1'b0, 1'b0);
      add(1'b1, 8'h1C, 1'b1, 6'h00, 6'h00, 6'h00, 1'b0, 9'h16B, 1'b0, 1'b0);
      add(1'b1, 8'hF0, 1'b0, 6'h00, 6'h00, 6'h00, 1'b0, 9'h16B, 1'b0, 1'b0);
      add(1'b1, 8'h1B, 1'b0, 6'h00, 6'h00, 6'h00, 1'b1, 9'h01B, 1'b1, 1'b0);

      // Reset state.
      model_reset();
      repeat (3) @(negedge CLOCK_50);
      check("reset held",   32'(keys_held),  32'h0);
      check("reset code",   32'(last_code),  32'h0);
      check("reset brk",    32'(last_break), 32'h0);
      check("reset cv",     32'(code_valid), 32'h0);
      check("reset err",    32'(seq_error),  32'h0);
      check("reset pulses", 32'(key_pressed | key_released), 32'h0);
      reset = 1'b0;

      foreach (tbl[i]) begin
         drive_cycle(tbl[i].en, tbl[i].data, tbl[i].clr);
         check($sformatf("vec%0d held", i),     32'(keys_held),    32'(tbl[i].held));
         check($sformatf("vec%0d pressed", i),  32'(key_pressed),  32'(tbl[i].pr));
         check($sformatf("vec%0d released", i), 32'(key_released), 32'(tbl[i].rel));
         check($sformatf("vec%0d cv", i),       32'(code_valid),   32'(tbl[i].cv));
         check($sformatf("vec%0d code", i),     32'(last_code),    32'(tbl[i].code));
         check($sformatf("vec%0d brk", i),      32'(last_break),   32'(tbl[i].brk));
         check($sformatf("vec%0d err", i),      32'(seq_error),    32'(tbl[i].err));
      end

      // Prefix timeout: F0 then TMO idle cycles.
      drive_cycle(1'b1, 8'hF0, 1'b0);
      for (int k = 1; k < TMO; k++) begin
         drive_cycle(1'b0, 8'h00, 1'b0);
         check_model("tmo wait");
      end
      drive_cycle(1'b0, 8'h00, 1'b0);
      check("timeout seq_error", 32'(seq_error), 32'h1);
      drive_cycle(1'b0, 8'h00, 1'b0);
      check("timeout pulse width", 32'(seq_error), 32'h0);
      drive_cycle(1'b1, 8'h23, 1'b0);
      check("after timeout held", 32'(keys_held), 32'h04);
      check_model("after timeout");
      drive_cycle(1'b1, 8'hF0, 1'b0);
      drive_cycle(1'b1, 8'h23, 1'b0);
      check_model("release d");

      // Reset in the middle of E0 F0 while two keys are held.
      drive_cycle(1'b1, 8'h1C, 1'b0);
      drive_cycle(1'b1, 8'h29, 1'b0);
      check("pre-reset held", 32'(keys_held), 32'h11);
      drive_cycle(1'b1, 8'hE0, 1'b0);
      drive_cycle(1'b1, 8'hF0, 1'b0);
      #2 reset = 1'b1;
      #1;
      check("async reset held", 32'(keys_held), 32'h0);
      check("async reset code", 32'(last_code), 32'h0);
      received_data_en = 1'b1;
      received_data = 8'h1C;
      @(negedge CLOCK_50);
      @(negedge CLOCK_50);
      received_data_en = 1'b0;
      check("strobe in reset", 32'(keys_held), 32'h0);
      reset = 1'b0;
      model_reset();
      drive_cycle(1'b1, 8'h2B, 1'b0);
      check("post-reset held", 32'(keys_held), 32'h08);
      check_model("post reset");

      // Random bytes biased towards prefixes and tracked codes.
      for (int n = 0; n < 2500; n++) begin
         if (n % 500 == 250) begin
            drive_cycle(1'b1, 8'hE1, 1'b0);
            check_model("burst start");
            for (int k = 0; k < TMO + 5; k++) begin
               drive_cycle(1'b0, 8'h00, 1'b0);
               check_model("burst idle");
            end
         end else begin
            en  = ($urandom_range(0, 99) < 45);
            clr = ($urandom_range(0, 99) == 0);
            case ($urandom_range(0, 9))
               0: b = 8'hE0;
               1: b = 8'hF0;
               2: b = 8'hE1;
               3, 4, 5, 6: b = key_tab[9*$urandom_range(0, NK-1) +: 8];
               default: b = 8'($urandom);
            endcase
            drive_cycle(en, b, clr);
            check_model("rand");
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ps2_key_tracker.md
PS2_KEY_TRACKER -- requirements
Module: ps2_key_tracker

Interface
REQ-001 Parameter NUM_KEYS, 6, number of tracked key slots (1..32).
REQ-002 Parameter KEY_CODES, {9'h16B,9'h029,9'h02B,9'h023,9'h01B,9'h01C}, flat NUM_KEYS*9-bit table; slot i = bits [9i+8:9i] = {extended, scan code}; slot 0 at LSB (defaults: A,S,D,F,Space,E0-LeftArrow).
REQ-003 Parameter TIMEOUT_CYCLES, 100000, prefix-abandon timeout in clock cycles (2 ms at 50 MHz).
REQ-004 The clock and reset SHALL be: one clock CLOCK_50; reset is asynchronous and active-high, port reset.
REQ-005 CLOCK_50  input  1  system clock.
REQ-006 reset  input  1  asynchronous active-high reset.
REQ-007 received_data  input  8  byte from PS2_Controller, valid only when strobe high.
REQ-008 received_data_en  input  1  single-cycle byte strobe, CLOCK_50 domain.
REQ-009 clear_all  input  1  synchronous flush of key state and decoder.
REQ-010 keys_held  output  NUM_KEYS  level, 1 while slot key is down.
REQ-011 key_pressed  output  NUM_KEYS  one-cycle pulse on first make of slot key.
REQ-012 key_released  output  NUM_KEYS  one-cycle pulse on break of held slot key.
REQ-013 last_code  output  9  {extended, code} of last completed make/break.
REQ-014 last_break  output  1  1 if last_code was a break.
REQ-015 code_valid  output  1  one-cycle pulse when last_code updates.
REQ-016 seq_error  output  1  one-cycle pulse on prefix timeout or malformed sequence.

Function
REQ-017 All logic SHALL be clocked by CLOCK_50 only; received_data_en SHALL be sampled as a synchronous enable, never as a clock.
REQ-018 Decoder FSM states SHALL be IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen), PAUSE (E1 seen).
REQ-019 IDLE: E0->EXT; F0->BRK; E1->PAUSE; other byte->complete make {0,byte}, stay IDLE.
REQ-020 EXT: F0->EXT_BRK; other byte->complete make {1,byte}->IDLE. BRK: byte->complete break {0,byte}->IDLE. EXT_BRK: byte->complete break {1,byte}->IDLE.
REQ-021 E0, F0 or E1 received in BRK or EXT_BRK, or E0/E1 in EXT, SHALL pulse seq_error and restart decode treating the byte as first of a new sequence.
REQ-022 PAUSE SHALL discard exactly 7 further bytes via a 3-bit counter, then return to IDLE with no completed code and no key change.
REQ-023 In any state other than IDLE, TIMEOUT_CYCLES cycles without a strobe SHALL pulse seq_error and return to IDLE; the counter SHALL restart on every strobe.
REQ-024 Completed code with strobe in cycle N: last_code, last_break, code_valid, keys_held, key_pressed, key_released SHALL all update in cycle N+1 (latency 1).
REQ-025 Make matching slot i with keys_held[i]=0: set keys_held[i], pulse key_pressed[i]; with keys_held[i]=1 (typematic repeat): no pulse.
REQ-026 Break matching slot i with keys_held[i]=1: clear keys_held[i], pulse key_released[i]; with keys_held[i]=0: no pulse.
REQ-027 Codes matching no slot SHALL still pulse code_valid and update last_code; duplicate table entries SHALL all update.
REQ-028 Any number of keys SHALL be holdable simultaneously; matching is exact on all 9 bits.
REQ-029 clear_all SHALL, next cycle, zero keys_held, return FSM to IDLE, clear timeout and pause counters, emit no pulses; a strobe in the same cycle is discarded.

Reset
REQ-030 On reset: FSM=IDLE, counters=0, keys_held=0, all pulse outputs=0, last_code=9'h000, last_break=0; effective immediately, strobes ignored while asserted.
REQ-031 Reset mid-sequence SHALL discard the partial sequence; first byte after release is decoded from IDLE.

Structure
REQ-032 Shared package/include ps2_defs SHALL hold prefix constants (8'hE0, 8'hF0, 8'hE1), PAUSE_TAIL_BYTES=7 and FSM state encodings.
REQ-033 One sub-module ps2_key_slot (one instance per slot via generate) SHALL hold a slot's held bit and pulse logic given code, break flag and complete strobe.

Verification
REQ-034 Strobe 1C -> next cycle keys_held[0]=1, key_pressed[0] pulse, last_code=9'h01C, last_break=0.
REQ-035 1C,1C,1C then F0,1C -> one key_pressed[0] pulse only, three code_valid; after F0 1C keys_held=0, one key_released[0] pulse.
REQ-036 E0,6B then E0,F0,6B -> keys_held[5] set then cleared; plain 6B never affects slot 5.
REQ-037 E1 + 7 bytes (14 77 E1 F0 14 F0 77) then 1B -> no code_valid during pause; 1B sets keys_held[1].
REQ-038 F0 then no strobe for 100000 cycles -> seq_error pulse, FSM IDLE; following 23 sets keys_held[2].
REQ-039 Hold 1C and 29, assert reset mid E0 F0 sequence -> keys_held=0 immediately; after release 2B sets keys_held[3] only.
